axi4l_mst: RTL and testbench
============================

AXI4L_MST -- requirements
Module: axi4l_mst

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 12, AXI and command address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, data width (32 only); strobe width is C_DATA_WIDTH/8.
REQ-003 SHALL have parameter C_TIMEOUT, default 256, watchdog limit in cycles (used only under REQ-027).
REQ-004 SHALL have one clock and one reset: aclk in 1 clock; aresetn in 1, asynchronous active-low reset.
REQ-005 SHALL have cmd_valid in 1 and cmd_ready out 1: command handshake.
REQ-006 SHALL have cmd_write in 1: 1=write, 0=read.
REQ-007 SHALL have cmd_addr in C_ADDR_WIDTH, cmd_wdata in C_DATA_WIDTH and cmd_wstrb in C_DATA_WIDTH/8: command payload.
REQ-008 SHALL have rsp_valid out 1 and rsp_ready in 1: response handshake.
REQ-009 SHALL have rsp_rdata out C_DATA_WIDTH (read data, 0 for writes) and rsp_resp out 2 (BRESP/RRESP).
REQ-010 SHALL have m_axi_awaddr/awprot/awvalid out and m_axi_awready in: AW channel.
REQ-011 SHALL have m_axi_wdata/wstrb/wvalid out and m_axi_wready in: W channel.
REQ-012 SHALL have m_axi_bresp/bvalid in and m_axi_bready out: B channel.
REQ-013 SHALL have m_axi_araddr/arprot/arvalid out and m_axi_arready in: AR channel.
REQ-014 SHALL have m_axi_rdata/rresp/rvalid in and m_axi_rready out: R channel.
REQ-015 SHALL have timeout_err out 1: sticky watchdog flag.

Function
REQ-016 SHALL implement FSM states IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RSP; one outstanding transaction.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready, register the payload and go to WR or RD_ADDR.
REQ-018 SHALL assert awvalid and wvalid together in the cycle after acceptance; each stays high, payload stable, until its own ready is sampled high; AW and W may complete in either order or together.
REQ-019 SHALL enter WR_RESP once both AW and W handshakes have completed; bready=1 only in WR_RESP; on bvalid capture bresp, set rsp_rdata=0 and go to RSP.
REQ-020 SHALL hold arvalid high in RD_ADDR until arready; in RD_DATA rready=1; on rvalid capture rdata/rresp and go to RSP.
REQ-021 SHALL drive awprot=arprot=3'b000 always.
REQ-022 SHALL hold rsp_valid=1 in RSP with rsp_rdata/rsp_resp stable until rsp_ready; then return to IDLE.
REQ-023 SHALL register all AXI and rsp outputs (no combinational path from any input to any output).
REQ-024 SHALL give latency from cmd acceptance to rsp_valid of exactly 3 cycles when the slave asserts all readies and bvalid/rvalid in the cycle after each request is presented.
REQ-025 SHALL NOT accept a new command in the cycle rsp_ready completes; the next acceptance is at the earliest one cycle later in IDLE.

Reset
REQ-026 SHALL, on aresetn low at any time including mid-transaction, go to IDLE at once and clear all valid/ready outputs, cmd_ready, rsp_valid, rsp_rdata, rsp_resp and timeout_err to 0; cmd_ready becomes 1 on the first clock after release.

Configuration
REQ-027 SHALL, when AXI4L_MST_TIMEOUT_EN is defined, count cycles spent in WR/WR_RESP/RD_ADDR/RD_DATA; at C_TIMEOUT it drops all AXI valid/ready, sets timeout_err (sticky until reset), and enters RSP with rsp_resp=2'b10 and rsp_rdata=0.
REQ-028 SHALL, without AXI4L_MST_TIMEOUT_EN, remove the counter, tie timeout_err to 0 and wait on the slave indefinitely.

Verification
REQ-029 SHALL cover write 0x000<-0xABCD1234, strb 4'hF, slave readies immediate -> AW and W in the same cycle, rsp_resp=00, rsp_valid 3 cycles after acceptance.
REQ-030 SHALL cover a write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles, exactly one rsp.
REQ-031 SHALL cover read 0x004 with slave rdata 0xABCD1234 and rresp 00 -> rsp_rdata=0xABCD1234, rsp_resp=00.
REQ-032 SHALL cover rsp_ready held low 10 cycles -> rsp_valid held, payload stable, cmd_ready=0 throughout.
REQ-033 SHALL cover aresetn asserted while awvalid is high -> all outputs 0 immediately, and after release a read completes normally.
REQ-034 SHALL cover, with AXI4L_MST_TIMEOUT_EN and C_TIMEOUT=16, a slave that never asserts arready -> rsp_resp=10 and timeout_err=1 after 16 cycles.

Source files
------------

// File: rtl/axi4l_mst_if.sv
// rtl/axi4l_mst_if.sv - AXI4-Lite bus bundle between axi4l_mst and a slave
interface axi4l_mst_if #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [C_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [C_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4l_mst.sv
// rtl/axi4l_mst.sv - single-outstanding AXI4-Lite master driven by a cmd/rsp handshake
// Optional watchdog enabled by defining AXI4L_MST_TIMEOUT_EN.
module axi4l_mst #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_TIMEOUT    = 256
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      timeout_err,
    axi4l_mst_if.master               m_axi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                    state_q, state_n;
    logic [C_ADDR_WIDTH-1:0]   addr_q;
    logic [C_DATA_WIDTH-1:0]   wdata_q;
    logic [C_DATA_WIDTH/8-1:0] wstrb_q;
    logic                      awvalid_q, awvalid_n;
    logic                      wvalid_q, wvalid_n;
    logic                      bready_q, bready_n;
    logic                      arvalid_q, arvalid_n;
    logic                      rready_q, rready_n;
    logic                      cmd_ready_q, cmd_ready_n;
    logic                      rsp_valid_q, rsp_valid_n;
    logic [C_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_n;
    logic [1:0]                rsp_resp_q, rsp_resp_n;
    logic                      load;
    logic                      fire_timeout;

`ifdef AXI4L_MST_TIMEOUT_EN
    localparam int CNT_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_q;
    logic             busy;
    logic             natural_rsp;

    assign busy        = (state_q == WR) || (state_q == WR_RESP) ||
                         (state_q == RD_ADDR) || (state_q == RD_DATA);
    // A response arriving on the expiry cycle still wins over the watchdog.
    assign natural_rsp = ((state_q == WR_RESP) && m_axi.bvalid) ||
                         ((state_q == RD_DATA) && m_axi.rvalid);
    assign fire_timeout = busy && !natural_rsp && (cnt_q == CNT_W'(C_TIMEOUT - 1));
    assign timeout_err  = tmo_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= busy ? cnt_q + 1'b1 : '0;
            tmo_q <= tmo_q | fire_timeout;
        end
    end
`else
    logic unused_timeout;

    // Watchdog compiled out: C_TIMEOUT has no effect in this build.
    assign unused_timeout = (C_TIMEOUT == 0);
    assign fire_timeout   = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_n     = state_q;
        load        = 1'b0;
        awvalid_n   = awvalid_q;
        wvalid_n    = wvalid_q;
        bready_n    = 1'b0;
        arvalid_n   = arvalid_q;
        rready_n    = 1'b0;
        rsp_valid_n = rsp_valid_q;
        rsp_rdata_n = rsp_rdata_q;
        rsp_resp_n  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    load = 1'b1;
                    if (cmd_write) begin
                        state_n   = WR;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = RD_ADDR;
                        arvalid_n = 1'b1;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; leave once both are done.
                awvalid_n = awvalid_q && !m_axi.awready;
                wvalid_n  = wvalid_q && !m_axi.wready;
                if (!awvalid_n && !wvalid_n) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end
            end
            WR_RESP: begin
                bready_n = 1'b1;
                if (m_axi.bvalid && bready_q) begin
                    bready_n    = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = '0;
                    rsp_resp_n  = m_axi.bresp;
                    state_n     = RSP;
                end
            end
            RD_ADDR: begin
                if (m_axi.arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_DATA;
                end
            end
            RD_DATA: begin
                rready_n = 1'b1;
                if (m_axi.rvalid && rready_q) begin
                    rready_n    = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = m_axi.rdata;
                    rsp_resp_n  = m_axi.rresp;
                    state_n     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (fire_timeout) begin
            state_n     = RSP;
            awvalid_n   = 1'b0;
            wvalid_n    = 1'b0;
            bready_n    = 1'b0;
            arvalid_n   = 1'b0;
            rready_n    = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_rdata_n = '0;
            rsp_resp_n  = 2'b10;
        end

        cmd_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_n;
            awvalid_q   <= awvalid_n;
            wvalid_q    <= wvalid_n;
            bready_q    <= bready_n;
            arvalid_q   <= arvalid_n;
            rready_q    <= rready_n;
            cmd_ready_q <= cmd_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_resp_q  <= rsp_resp_n;
            if (load) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4l_mst.sv
// tb/tb_axi4l_mst.sv - directed vector bench for axi4l_mst with a delay-programmable slave
module tb_axi4l_mst;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_err;

    axi4l_mst_if #(.C_ADDR_WIDTH(12), .C_DATA_WIDTH(32)) axi ();

    axi4l_mst #(.C_ADDR_WIDTH(12), .C_DATA_WIDTH(32), .C_TIMEOUT(16)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .timeout_err (timeout_err),
        .m_axi       (axi)
    );

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        int          ar_dly;
        int          r_dly;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        int          hold;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_aw;
        int          exp_w;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    int          aw_hi, w_hi;
    logic [11:0] cap_awaddr, cap_araddr;
    logic [2:0]  cap_prot;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish got running expected done");
        $fatal(1, "global timeout");
    end

    // Slave: each channel answers after a programmable number of cycles.
    initial begin
        int aw_n, w_n, b_n, ar_n, r_n;
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        forever begin
            @(negedge aclk);
            if (axi.awvalid) begin
                aw_hi++;
                axi.awready = (aw_n >= aw_dly);
                if (axi.awready) begin
                    cap_awaddr = axi.awaddr;
                    cap_prot   = axi.awprot;
                end
                aw_n++;
            end else begin
                axi.awready = 1'b0;
                aw_n = 0;
            end
            if (axi.wvalid) begin
                w_hi++;
                axi.wready = (w_n >= w_dly);
                if (axi.wready) begin
                    cap_wdata = axi.wdata;
                    cap_wstrb = axi.wstrb;
                end
                w_n++;
            end else begin
                axi.wready = 1'b0;
                w_n = 0;
            end
            if (axi.bready) begin
                axi.bvalid = (b_n >= b_dly);
                axi.bresp  = s_resp;
                b_n++;
            end else begin
                axi.bvalid = 1'b0;
                b_n = 0;
            end
            if (axi.arvalid) begin
                axi.arready = (ar_n >= ar_dly);
                if (axi.arready) begin
                    cap_araddr = axi.araddr;
                    cap_prot   = axi.arprot;
                end
                ar_n++;
            end else begin
                axi.arready = 1'b0;
                ar_n = 0;
            end
            if (axi.rready) begin
                axi.rvalid = (r_n >= r_dly);
                axi.rdata  = s_rdata;
                axi.rresp  = s_resp;
                r_n++;
            end else begin
                axi.rvalid = 1'b0;
                r_n = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_slave(input vec_t v);
        aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly;
        ar_dly = v.ar_dly; r_dly = v.r_dly;
        s_rdata = v.s_rdata; s_resp = v.s_resp;
    endtask

    // Presents the command and returns once it has been accepted.
    task automatic issue(input vec_t v, input string tag, output bit ok);
        int n;
        cfg_slave(v);
        @(negedge aclk);
        aw_hi = 0; w_hi = 0;
        cap_awaddr = 12'hEEE; cap_araddr = 12'hEEE; cap_prot = 3'b111;
        cap_wdata = 32'hDEADDEAD; cap_wstrb = 4'h0;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        ok = (n < 20);
        if (!ok) begin
            chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        bit stable;
        int lat;
        issue(v, tag, ok);
        if (!ok) return;
        @(negedge aclk);
        cmd_valid = 1'b0;
        lat = 1;
        chk({tag, "_busy_cmd_ready"}, 32'(cmd_ready), 32'd0);
        while (rsp_valid !== 1'b1 && lat < 60) begin
            @(negedge aclk);
            lat++;
        end
        if (lat >= 60) begin
            chk({tag, "_rsp_wait"}, 32'(rsp_valid), 32'd1);
            return;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_resp"}, 32'(rsp_resp), 32'(v.exp_resp));
        if (v.ar_dly < 1000 && v.aw_dly < 1000) begin
            chk({tag, "_prot"}, 32'(cap_prot), 32'd0);
            if (v.wr) begin
                chk({tag, "_aw_cycles"}, 32'(aw_hi), 32'(v.exp_aw));
                chk({tag, "_w_cycles"}, 32'(w_hi), 32'(v.exp_w));
                chk({tag, "_awaddr"}, 32'(cap_awaddr), 32'(v.addr));
                chk({tag, "_wdata"}, cap_wdata, v.wdata);
                chk({tag, "_wstrb"}, 32'(cap_wstrb), 32'(v.wstrb));
            end else begin
                chk({tag, "_araddr"}, 32'(cap_araddr), 32'(v.addr));
            end
        end
        if (v.hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                @(negedge aclk);
                if (rsp_valid !== 1'b1 || rsp_rdata !== v.exp_rdata ||
                    rsp_resp !== v.exp_resp || cmd_ready !== 1'b0)
                    stable = 1'b0;
            end
            chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
    endtask

    vec_t vecs[5];
    vec_t v_hang;
    vec_t v_tmo;

    initial begin
        bit ok;
        vecs[0] = '{1'b1, 12'h000, 32'hABCD1234, 4'hF, 0, 0, 0, 0, 0,
                    32'h0, 2'b00, 0, 3, 32'h0, 2'b00, 1, 1};
        vecs[1] = '{1'b1, 12'h010, 32'h5555AAAA, 4'h3, 4, 0, 0, 0, 0,
                    32'h0, 2'b00, 0, 7, 32'h0, 2'b00, 5, 1};
        vecs[2] = '{1'b0, 12'h004, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                    32'hABCD1234, 2'b00, 0, 3, 32'hABCD1234, 2'b00, 0, 0};
        vecs[3] = '{1'b0, 12'hFFC, 32'h0, 4'h0, 0, 0, 0, 2, 1,
                    32'h0BADF00D, 2'b10, 10, 6, 32'h0BADF00D, 2'b10, 0, 0};
        vecs[4] = '{1'b1, 12'h7F0, 32'h13579BDF, 4'hC, 0, 3, 2, 0, 0,
                    32'hFFFFFFFF, 2'b11, 2, 8, 32'h0, 2'b11, 1, 4};
        v_hang  = '{1'b1, 12'h020, 32'hCAFEBABE, 4'hF, 1000, 1000, 0, 0, 0,
                    32'h0, 2'b00, 0, 0, 32'h0, 2'b00, 0, 0};
        v_tmo   = '{1'b0, 12'h0A0, 32'h0, 4'h0, 0, 0, 0, 1000, 0,
                    32'h12345678, 2'b00, 0, 17, 32'h0, 2'b10, 0, 0};

        aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        cfg_slave(vecs[0]);
        repeat (3) @(negedge aclk);
        chk("reset_outputs", {23'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                              axi.rready, cmd_ready, rsp_valid, rsp_resp, timeout_err}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while the write address is still outstanding.
        issue(v_hang, "hang", ok);
        if (ok) begin
            @(negedge aclk);
            cmd_valid = 1'b0;
            repeat (8) @(negedge aclk);
            chk("hang_waiting", {29'd0, axi.awvalid, axi.wvalid, rsp_valid}, 32'b110);
            #2 aresetn = 1'b0;
            #1;
            chk("midreset_outputs", {23'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                                     axi.rready, cmd_ready, rsp_valid, rsp_resp, timeout_err}, 32'd0);
            chk("midreset_rdata", rsp_rdata, 32'd0);
            cfg_slave(vecs[2]);
            @(negedge aclk);
            aresetn = 1'b1;
            @(posedge aclk);
            #1;
            chk("midreset_release_cmd_ready", 32'(cmd_ready), 32'd1);
            run_vec(vecs[2], "post_reset_read");
        end

`ifdef AXI4L_MST_TIMEOUT_EN
        run_vec(v_tmo, "timeout");
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        run_vec(vecs[0], "after_timeout");
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
`else
        chk("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
